pupil_blob_locator: RTL

- Consumer of the binarised pixel stream produced by the double-threshold stage (valid + 8-bit pixel, 0x00 = background, 0xFF = foreground).
- Tracks raster position, accumulates the foreground bounding box and pixel count per frame, and presents the pupil box and centre on a held valid/ready result port.
- Sits at the tail of the pupil-detection pipeline and feeds downstream overlay or readout logic.

---
 rtl/img_pkg.sv | 25 ++
 rtl/pupil_blob_locator_if.sv | 35 +++
 rtl/raster_counter.sv | 53 +++++
 rtl/pupil_blob_locator.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Frame geometry defaults, derived widths and the pixel classification helper
// shared by the pupil-detection blocks and their sliding_window users.
package img_pkg;

    localparam int pixel_width         = 8;
    localparam int default_data_width  = 8;
    localparam int default_line_width  = 637;
    localparam int default_frame_lines = 480;
    localparam int default_min_pixels  = 16;

    localparam int default_xw = $clog2(default_line_width);
    localparam int default_yw = $clog2(default_frame_lines);
    localparam int default_cw = $clog2(default_line_width * default_frame_lines + 1);

    typedef enum logic {
        RESULT_EMPTY,
        RESULT_FULL
    } result_state_t;

    // MSB test written as a compare so every bit of the byte is read.
    function automatic logic is_foreground(input logic [pixel_width-1:0] pixel);
        return pixel >= {1'b1, {(pixel_width-1){1'b0}}};
    endfunction

endpackage

// File: rtl/pupil_blob_locator_if.sv
// Pixel-stream input and held valid/ready result port of the pupil blob locator.
interface pupil_blob_locator_if import img_pkg::*; #(
    parameter int data_width = default_data_width,
    parameter int XW         = default_xw,
    parameter int YW         = default_yw,
    parameter int CW         = default_cw
);
    logic                  data_valid;
    logic [data_width-1:0] data_in;
    logic                  sof;
    logic                  result_ready;
    logic                  result_valid;
    logic                  found;
    logic [XW-1:0]         x_min;
    logic [XW-1:0]         x_max;
    logic [YW-1:0]         y_min;
    logic [YW-1:0]         y_max;
    logic [XW-1:0]         x_center;
    logic [YW-1:0]         y_center;
    logic [CW-1:0]         pixel_count;
    logic                  overrun;

    modport master (
        output data_valid, data_in, sof, result_ready,
        input  result_valid, found, x_min, x_max, y_min, y_max,
               x_center, y_center, pixel_count, overrun
    );

    modport slave (
        input  data_valid, data_in, sof, result_ready,
        output result_valid, found, x_min, x_max, y_min, y_max,
               x_center, y_center, pixel_count, overrun
    );

endinterface

// File: rtl/raster_counter.sv
// Raster position of the current pixel with sof resync, plus first-pixel and
// end-of-frame strobes for the pixel being presented this cycle.
module raster_counter import img_pkg::*; #(
    parameter int line_width  = default_line_width,
    parameter int frame_lines = default_frame_lines,
    parameter int XW          = $clog2(line_width),
    parameter int YW          = $clog2(frame_lines)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          data_valid,
    input  logic          sof,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          first_pixel,
    output logic          end_of_frame
);
    localparam logic [XW-1:0] last_col = XW'(line_width - 1);
    localparam logic [YW-1:0] last_row = YW'(frame_lines - 1);

    logic [XW-1:0] col_reg, col_next;
    logic [YW-1:0] row_reg, row_next;

    // The registers hold the position of the next pixel; sof overrides it.
    always_comb begin
        col          = (data_valid && sof) ? '0 : col_reg;
        row          = (data_valid && sof) ? '0 : row_reg;
        first_pixel  = data_valid && (col == '0) && (row == '0);
        end_of_frame = data_valid && (col == last_col) && (row == last_row);
        col_next     = col_reg;
        row_next     = row_reg;
        if (data_valid) begin
            if (col == last_col) begin
                col_next = '0;
                row_next = (row == last_row) ? '0 : row + 1'b1;
            end else begin
                col_next = col + 1'b1;
                row_next = row;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

endmodule

// File: rtl/pupil_blob_locator.sv
// Per-frame foreground bounding box, count and centre of a binarised pixel
// stream, presented on a held valid/ready result port with sticky overrun.
module pupil_blob_locator import img_pkg::*; #(
    parameter int data_width  = default_data_width,
    parameter int line_width  = default_line_width,
    parameter int frame_lines = default_frame_lines,
    parameter int min_pixels  = default_min_pixels
) (
    input  logic                  clock,
    input  logic                  rst_n,
    pupil_blob_locator_if.slave   bus
);
    localparam int XW = $clog2(line_width);
    localparam int YW = $clog2(frame_lines);
    localparam int CW = $clog2(line_width * frame_lines + 1);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          first_pixel;
    logic          end_of_frame;

    raster_counter #(
        .line_width  (line_width),
        .frame_lines (frame_lines),
        .XW          (XW),
        .YW          (YW)
    ) u_raster (
        .clock        (clock),
        .rst_n        (rst_n),
        .data_valid   (bus.data_valid),
        .sof          (bus.sof),
        .col          (col),
        .row          (row),
        .first_pixel  (first_pixel),
        .end_of_frame (end_of_frame)
    );

    logic [XW-1:0] acc_x_min_reg, acc_x_max_reg, acc_x_min_next, acc_x_max_next;
    logic [YW-1:0] acc_y_min_reg, acc_y_max_reg, acc_y_min_next, acc_y_max_next;
    logic [CW-1:0] acc_count_reg, acc_count_next;
    logic          fg;

    // The _next values include the current pixel; the first pixel of a frame
    // starts from a cleared box so an sof resync drops the partial frame.
    always_comb begin
        fg             = bus.data_valid && is_foreground(bus.data_in[data_width-1 -: pixel_width]);
        acc_x_min_next = first_pixel ? '1 : acc_x_min_reg;
        acc_x_max_next = first_pixel ? '0 : acc_x_max_reg;
        acc_y_min_next = first_pixel ? '1 : acc_y_min_reg;
        acc_y_max_next = first_pixel ? '0 : acc_y_max_reg;
        acc_count_next = first_pixel ? '0 : acc_count_reg;
        if (fg) begin
            if (col < acc_x_min_next) acc_x_min_next = col;
            if (col > acc_x_max_next) acc_x_max_next = col;
            if (row < acc_y_min_next) acc_y_min_next = row;
            if (row > acc_y_max_next) acc_y_max_next = row;
            acc_count_next = acc_count_next + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_min_reg <= '1;
            acc_x_max_reg <= '0;
            acc_y_min_reg <= '1;
            acc_y_max_reg <= '0;
            acc_count_reg <= '0;
        end else if (bus.data_valid) begin
            acc_x_min_reg <= end_of_frame ? '1 : acc_x_min_next;
            acc_x_max_reg <= end_of_frame ? '0 : acc_x_max_next;
            acc_y_min_reg <= end_of_frame ? '1 : acc_y_min_next;
            acc_y_max_reg <= end_of_frame ? '0 : acc_y_max_next;
            acc_count_reg <= end_of_frame ? '0 : acc_count_next;
        end
    end

    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;
    logic          found_now;
    logic          accept;
    logic          load_en;
    result_state_t state_reg;
    logic          result_valid_reg, overrun_reg, found_reg;
    logic [XW-1:0] res_x_min_reg, res_x_max_reg, res_x_center_reg;
    logic [YW-1:0] res_y_min_reg, res_y_max_reg, res_y_center_reg;
    logic [CW-1:0] res_count_reg;

    assign x_sum     = {1'b0, acc_x_min_next} + {1'b0, acc_x_max_next};
    assign y_sum     = {1'b0, acc_y_min_next} + {1'b0, acc_y_max_next};
    assign found_now = acc_count_next >= CW'(min_pixels);
    assign accept    = result_valid_reg && bus.result_ready;
    assign load_en   = end_of_frame && ((state_reg == RESULT_EMPTY) || accept);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RESULT_EMPTY;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            found_reg        <= 1'b0;
            res_x_min_reg    <= '0;
            res_x_max_reg    <= '0;
            res_y_min_reg    <= '0;
            res_y_max_reg    <= '0;
            res_x_center_reg <= '0;
            res_y_center_reg <= '0;
            res_count_reg    <= '0;
        end else begin
            case (state_reg)
                RESULT_EMPTY: begin
                    if (end_of_frame) begin
                        state_reg        <= RESULT_FULL;
                        result_valid_reg <= 1'b1;
                    end
                end
                RESULT_FULL: begin
                    if (end_of_frame && !accept) begin
                        overrun_reg <= 1'b1;
                    end else if (accept && !end_of_frame) begin
                        state_reg        <= RESULT_EMPTY;
                        result_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= RESULT_EMPTY;
            endcase
            if (load_en) begin
                found_reg        <= found_now;
                res_x_min_reg    <= found_now ? acc_x_min_next : '0;
                res_x_max_reg    <= found_now ? acc_x_max_next : '0;
                res_y_min_reg    <= found_now ? acc_y_min_next : '0;
                res_y_max_reg    <= found_now ? acc_y_max_next : '0;
                res_x_center_reg <= found_now ? x_sum[XW:1] : '0;
                res_y_center_reg <= found_now ? y_sum[YW:1] : '0;
                res_count_reg    <= acc_count_next;
            end
        end
    end

    assign bus.result_valid = result_valid_reg;
    assign bus.overrun      = overrun_reg;
    assign bus.found        = found_reg;
    assign bus.x_min        = res_x_min_reg;
    assign bus.x_max        = res_x_max_reg;
    assign bus.y_min        = res_y_min_reg;
    assign bus.y_max        = res_y_max_reg;
    assign bus.x_center     = res_x_center_reg;
    assign bus.y_center     = res_y_center_reg;
    assign bus.pixel_count  = res_count_reg;

endmodule
